// File: rtl/wiring_sequencer.sv
// wiring_sequencer: front-end sequencer for a single Wiring instance.
// It accepts one trigger vector per request and optionally clears the lamps
// first. It fires the vector as a one-cycle pulse and waits for the Wiring
// to settle or for the cycle budget to run out. It then pulses logic_reset
// and returns the OR of the Wiring output, the settle count and a timeout
// flag over a valid/ready response handshake.
// All outputs are registered and decoded from the next state, so each
// output lines up with the current state and clears at once on reset.

module wiring_sequencer #(
    parameter int INPUT_WIDTH  = 3,
    parameter int OUTPUT_WIDTH = 1,
    parameter int CYCLE_WIDTH  = 16,
    parameter int MAX_CYCLES   = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [INPUT_WIDTH-1:0]  req_in,
    input  logic                    req_clear,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [OUTPUT_WIDTH-1:0] resp_out,
    output logic [CYCLE_WIDTH-1:0]  resp_cycles,
    output logic                    resp_timeout,
    output logic                    w_reset,
    output logic                    w_logic_reset,
    output logic [INPUT_WIDTH-1:0]  w_in,
    input  logic                    w_running,
    input  logic [OUTPUT_WIDTH-1:0] w_out,
    output logic                    busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PULSE = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    localparam logic [CYCLE_WIDTH-1:0]  CNT_ZERO = {CYCLE_WIDTH{1'b0}};
    localparam logic [CYCLE_WIDTH-1:0]  CNT_ONE  = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_WIDTH-1:0]  CNT_SAT  = {CYCLE_WIDTH{1'b1}};
    localparam logic [CYCLE_WIDTH-1:0]  CNT_MAX  = CYCLE_WIDTH'(MAX_CYCLES);
    localparam logic [INPUT_WIDTH-1:0]  VEC_ZERO = {INPUT_WIDTH{1'b0}};
    localparam logic [OUTPUT_WIDTH-1:0] ACC_ZERO = {OUTPUT_WIDTH{1'b0}};

    // control state and captured request data
    state_t                  state_r;
    state_t                  state_s;
    logic [INPUT_WIDTH-1:0]  vec_r;
    logic [INPUT_WIDTH-1:0]  vec_s;
    logic [OUTPUT_WIDTH-1:0] acc_r;
    logic [OUTPUT_WIDTH-1:0] acc_s;
    logic [CYCLE_WIDTH-1:0]  cnt_r;
    logic [CYCLE_WIDTH-1:0]  cnt_s;
    logic                    timeout_r;
    logic                    timeout_s;

    // registered outputs and their next-cycle values
    logic                    req_ready_r;
    logic                    req_ready_s;
    logic                    resp_valid_r;
    logic                    resp_valid_s;
    logic [OUTPUT_WIDTH-1:0] resp_out_r;
    logic [OUTPUT_WIDTH-1:0] resp_out_s;
    logic [CYCLE_WIDTH-1:0]  resp_cycles_r;
    logic [CYCLE_WIDTH-1:0]  resp_cycles_s;
    logic                    resp_timeout_r;
    logic                    resp_timeout_s;
    logic                    w_reset_r;
    logic                    w_reset_s;
    logic                    w_logic_reset_r;
    logic                    w_logic_reset_s;
    logic [INPUT_WIDTH-1:0]  w_in_r;
    logic [INPUT_WIDTH-1:0]  w_in_s;
    logic                    busy_r;
    logic                    busy_s;

    // next-state, capture, accumulate and settle-count logic
    always_comb begin
        state_s   = state_r;
        vec_s     = vec_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        timeout_s = timeout_r;
        case (state_r)
            ST_IDLE: begin
                // req_ready_r is low in the first cycle after reset, so the
                // accept is qualified by the registered ready.
                if (req_valid && req_ready_r) begin
                    vec_s     = req_in;
                    acc_s     = ACC_ZERO;
                    cnt_s     = CNT_ZERO;
                    timeout_s = 1'b0;
                    if (req_clear) begin
                        state_s = ST_CLEAR;
                    end else begin
                        state_s = ST_PULSE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_PULSE;
            end
            ST_PULSE: begin
                cnt_s   = CNT_ONE;
                acc_s   = acc_r | w_out;
                state_s = ST_RUN;
            end
            ST_RUN: begin
                acc_s = acc_r | w_out;
                if (!w_running) begin
                    // The settling cycle itself is not counted.
                    timeout_s = 1'b0;
                    state_s   = ST_FLUSH;
                end else if (cnt_r >= CNT_MAX) begin
                    timeout_s = 1'b1;
                    state_s   = ST_FLUSH;
                end else if (cnt_r != CNT_SAT) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_FLUSH: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // decode the output values for the state being entered next
    always_comb begin
        req_ready_s     = (state_s == ST_IDLE);
        w_reset_s       = (state_s == ST_CLEAR);
        w_logic_reset_s = (state_s == ST_FLUSH);
        resp_valid_s    = (state_s == ST_RESP);
        busy_s          = (state_s != ST_IDLE);
        if (state_s == ST_PULSE) begin
            w_in_s = vec_s;
        end else begin
            w_in_s = VEC_ZERO;
        end
        if (state_s == ST_RESP) begin
            resp_out_s     = acc_s;
            resp_cycles_s  = cnt_s;
            resp_timeout_s = timeout_s;
        end else begin
            resp_out_s     = ACC_ZERO;
            resp_cycles_s  = CNT_ZERO;
            resp_timeout_s = 1'b0;
        end
    end

    // state and captured-data registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            vec_r     <= VEC_ZERO;
            acc_r     <= ACC_ZERO;
            cnt_r     <= CNT_ZERO;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            vec_r     <= vec_s;
            acc_r     <= acc_s;
            cnt_r     <= cnt_s;
            timeout_r <= timeout_s;
        end
    end

    // output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_r     <= 1'b0;
            resp_valid_r    <= 1'b0;
            resp_out_r      <= ACC_ZERO;
            resp_cycles_r   <= CNT_ZERO;
            resp_timeout_r  <= 1'b0;
            w_reset_r       <= 1'b0;
            w_logic_reset_r <= 1'b0;
            w_in_r          <= VEC_ZERO;
            busy_r          <= 1'b0;
        end else begin
            req_ready_r     <= req_ready_s;
            resp_valid_r    <= resp_valid_s;
            resp_out_r      <= resp_out_s;
            resp_cycles_r   <= resp_cycles_s;
            resp_timeout_r  <= resp_timeout_s;
            w_reset_r       <= w_reset_s;
            w_logic_reset_r <= w_logic_reset_s;
            w_in_r          <= w_in_s;
            busy_r          <= busy_s;
        end
    end

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_out      = resp_out_r;
    assign resp_cycles   = resp_cycles_r;
    assign resp_timeout  = resp_timeout_r;
    assign w_reset       = w_reset_r;
    assign w_logic_reset = w_logic_reset_r;
    assign w_in          = w_in_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_wiring_sequencer.sv
// Directed, table-driven bench for wiring_sequencer with a settle budget of 4.
// Each record describes one request plus a scripted Wiring response. The
// script gives the number of RUN cycles with wiring_running high and the
// w_out value for each cycle. Bit 0 of wout is the PULSE cycle and bit i is
// RUN cycle i. The expected response fields are hand-computed.

module tb_wiring_sequencer;

    localparam int MAX = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_in;
    logic        req_clear;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_out;
    logic [15:0] resp_cycles;
    logic        resp_timeout;
    logic        w_reset;
    logic        w_logic_reset;
    logic [2:0]  w_in;
    logic        w_running;
    logic [0:0]  w_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] vec;
        logic       clr;
        int         n_high;
        logic [7:0] wout;
        logic       exp_out;
        int         exp_cyc;
        logic       exp_to;
        int         hold;
    } vec_t;

    vec_t tbl [9];

    wiring_sequencer #(
        .INPUT_WIDTH (3),
        .OUTPUT_WIDTH(1),
        .CYCLE_WIDTH (16),
        .MAX_CYCLES  (MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_in       (req_in),
        .req_clear    (req_clear),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_out     (resp_out),
        .resp_cycles  (resp_cycles),
        .resp_timeout (resp_timeout),
        .w_reset      (w_reset),
        .w_logic_reset(w_logic_reset),
        .w_in         (w_in),
        .w_running    (w_running),
        .w_out        (w_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One request/response transaction; the caller must be at a negedge.
    task automatic run_txn(input vec_t t);
        int pulse_c;
        int k;
        int flush_c;
        int resp_c;
        int waited;
        int r;
        pulse_c = t.clr ? 1 : 0;
        k       = t.exp_to ? MAX : t.n_high + 1;
        flush_c = pulse_c + k + 1;
        resp_c  = flush_c + 1;
        waited  = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid  = 1'b1;
        req_in     = t.vec;
        req_clear  = t.clr;
        resp_ready = (t.hold == 0);
        @(posedge clk);
        #1;
        // Changed values must be ignored after the accept cycle.
        req_valid = 1'b0;
        req_in    = ~t.vec;
        req_clear = ~t.clr;
        for (int c = 0; c <= resp_c; c++) begin
            @(negedge clk);
            chk("busy", busy, 1);
            chk("req_ready_busy", req_ready, 0);
            chk("w_reset", w_reset, (t.clr && c == 0));
            chk("w_in", w_in, (c == pulse_c) ? t.vec : 3'b000);
            chk("w_logic_reset", w_logic_reset, (c == flush_c));
            chk("resp_valid", resp_valid, (c == resp_c));
            if (c == resp_c) begin
                chk("resp_out", resp_out, t.exp_out);
                chk("resp_cycles", resp_cycles, t.exp_cyc);
                chk("resp_timeout", resp_timeout, t.exp_to);
            end else begin
                chk("resp_out_idle", resp_out, 0);
                chk("resp_cycles_idle", resp_cycles, 0);
                chk("resp_timeout_idle", resp_timeout, 0);
            end
            if (c == pulse_c) begin
                w_running = 1'b1;
                w_out     = t.wout[0];
            end else if (c > pulse_c) begin
                r         = c - pulse_c - 1;
                w_running = (r < t.n_high);
                w_out     = t.wout[r + 1];
            end else begin
                w_running = 1'b1;
                w_out     = 1'b1;
            end
        end
        if (t.hold > 0) begin
            req_valid = 1'b1;
            req_in    = 3'b111;
            req_clear = 1'b1;
            for (int h = 1; h < t.hold; h++) begin
                @(negedge clk);
                chk("hold_resp_valid", resp_valid, 1);
                chk("hold_resp_out", resp_out, t.exp_out);
                chk("hold_resp_cycles", resp_cycles, t.exp_cyc);
                chk("hold_resp_timeout", resp_timeout, t.exp_to);
                chk("hold_req_ready", req_ready, 0);
                chk("hold_busy", busy, 1);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("after_busy", busy, 0);
        chk("after_resp_valid", resp_valid, 0);
        chk("after_req_ready", req_ready, 1);
        chk("after_resp_cycles", resp_cycles, 0);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        w_running  = 1'b0;
        w_out      = 1'b0;
    endtask

    initial begin
        //           vec     clr   hi wout         out   cyc to    hold
        tbl[0] = '{3'b001, 1'b0, 2, 8'b0000_0010, 1'b1, 3, 1'b0, 0};
        tbl[1] = '{3'b101, 1'b1, 1, 8'b0000_0000, 1'b0, 2, 1'b0, 0};
        tbl[2] = '{3'b010, 1'b0, 4, 8'b0000_0001, 1'b1, 4, 1'b1, 0};
        tbl[3] = '{3'b011, 1'b1, 3, 8'b0001_0000, 1'b1, 4, 1'b0, 0};
        tbl[4] = '{3'b111, 1'b0, 5, 8'b0010_0000, 1'b0, 4, 1'b1, 0};
        tbl[5] = '{3'b100, 1'b0, 0, 8'b0000_0001, 1'b1, 1, 1'b0, 5};
        tbl[6] = '{3'b000, 1'b0, 0, 8'b0000_0000, 1'b0, 1, 1'b0, 0};
        tbl[7] = '{3'b110, 1'b0, 1, 8'b0000_0100, 1'b1, 2, 1'b0, 0};
        tbl[8] = '{3'b111, 1'b1, 2, 8'b0000_0000, 1'b0, 3, 1'b0, 0};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_in     = 3'b000;
        req_clear  = 1'b0;
        resp_ready = 1'b1;
        w_running  = 1'b0;
        w_out      = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_w_in", w_in, 0);
        chk("rst_w_logic_reset", w_logic_reset, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i]);
        end

        // Asynchronous reset in the middle of RUN.
        req_valid = 1'b1;
        req_in    = 3'b011;
        req_clear = 1'b0;
        w_running = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_pre_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_w_in", w_in, 0);
        chk("arst_w_logic_reset", w_logic_reset, 0);
        chk("arst_resp_valid", resp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_hold_resp_valid", resp_valid, 0);
            chk("arst_hold_w_logic_reset", w_logic_reset, 0);
        end
        reset     = 1'b1;
        w_running = 1'b0;
        @(negedge clk);
        chk("arst_release_req_ready", req_ready, 1);
        chk("arst_release_busy", busy, 0);
        run_txn(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
